// File: rtl/snoop_responder.sv
// snoop_responder: per-core MSI snooper that looks up foreign bus ops in the local tag array,
// flushes MODIFIED blocks to memory, then downgrades/invalidates the line and pulses snoop_done.
module snoop_responder #(
    parameter int CORE_ID = 0,
    parameter int INDEX_W = 6,
    parameter int BLK_WORDS = 4,
    localparam int OFF_W = $clog2(BLK_WORDS),
    localparam int TAG_W = 16 - INDEX_W - OFF_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bus_valid,
    input  logic [2:0]              bus_op,
    input  logic [15:0]             bus_addr,
    output logic                    snoop_busy,
    output logic                    tag_rd_en,
    output logic [INDEX_W-1:0]      tag_idx,
    input  logic [TAG_W-1:0]        tag_rd_tag,
    input  logic [1:0]              tag_rd_state,
    input  logic [16*BLK_WORDS-1:0] blk_rd_data,
    output logic                    tag_we,
    output logic [1:0]              tag_wr_state,
    output logic                    wb_req,
    output logic [15:0]             wb_addr,
    output logic [16*BLK_WORDS-1:0] wb_data,
    input  logic                    wb_ack,
    output logic                    snoop_done,
    output logic                    snoop_hit,
    output logic                    proto_err
);
    localparam logic [2:0] S_IDLE = 3'd0, S_LOOKUP = 3'd1, S_WB = 3'd2, S_UPDATE = 3'd3, S_DRAIN = 3'd4;
    localparam logic [1:0] ST_INV = 2'd0, ST_SH = 2'd1, ST_MOD = 2'd2;

    logic [2:0]              state;
    logic [2:0]              op_r;
    logic [15:0]             addr_r;
    logic [16*BLK_WORDS-1:0] data_r;
    logic [1:0]              old_st, new_st;
    logic                    hit_r, err_r;
    logic                    accept, own_in, hit, is_mod, is_rm, is_inv, need_wb;
    logic [1:0]              nxt_st;

    // op encoding: 1/2 READ_MISS_0/1, 3/4 WRITE_MISS_0/1, 5/6 INVALIDATE_0/1; odd codes belong to core 0
    assign own_in  = bus_op[0] == (CORE_ID == 0);
    assign accept  = state == S_IDLE && bus_valid && bus_op != 3'd0 && bus_op != 3'd7;
    assign is_rm   = op_r inside {3'd1, 3'd2};
    assign is_inv  = op_r inside {3'd5, 3'd6};
    assign hit     = tag_rd_tag == addr_r[15 -: TAG_W] && tag_rd_state != ST_INV;
    assign is_mod  = tag_rd_state == ST_MOD;
    assign need_wb = hit && is_mod && !is_inv;
    assign nxt_st  = !hit ? tag_rd_state : is_rm ? (is_mod ? ST_SH : tag_rd_state) : ST_INV;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_r   <= '0;
            addr_r <= '0;
            data_r <= '0;
            old_st <= '0;
            new_st <= '0;
            hit_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_r   <= bus_op;
                    addr_r <= bus_addr;
                    hit_r  <= 1'b0;
                    err_r  <= 1'b0;
                    state  <= own_in ? S_UPDATE : S_LOOKUP;
                end
                S_LOOKUP: begin
                    data_r <= blk_rd_data;
                    old_st <= tag_rd_state;
                    new_st <= nxt_st;
                    hit_r  <= hit;
                    err_r  <= hit && is_mod && is_inv;
                    state  <= need_wb ? S_WB : S_UPDATE;
                end
                S_WB:     if (wb_ack) state <= S_UPDATE;
                S_UPDATE: state <= S_DRAIN;
                S_DRAIN:  if (!bus_valid) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign snoop_busy   = state != S_IDLE;
    assign tag_rd_en    = accept && !own_in;
    assign tag_idx      = state == S_IDLE ? bus_addr[OFF_W +: INDEX_W] : addr_r[OFF_W +: INDEX_W];
    assign wb_req       = state == S_WB;
    assign wb_addr      = addr_r & ~16'(BLK_WORDS - 1);
    assign wb_data      = data_r;
    assign snoop_done   = state == S_UPDATE;
    assign snoop_hit    = snoop_done && hit_r;
    assign proto_err    = snoop_done && err_r;
    assign tag_we       = snoop_done && hit_r && new_st != old_st;
    assign tag_wr_state = tag_we ? new_st : 2'd0;
endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder: drives directed and random bus ops against a bench-side cache array
// and a transaction-level MSI model, checking every output on every cycle.
module tb_snoop_responder;
    localparam logic [2:0] NOOP = 3'd0, RM0 = 3'd1, RM1 = 3'd2, WM0 = 3'd3, WM1 = 3'd4, INV0 = 3'd5, INV1 = 3'd6;
    localparam logic [1:0] I = 2'd0, S = 2'd1, M = 2'd2;

    logic        clk = 0, rst_n = 0;
    logic        bus_valid = 0, wb_ack = 0;
    logic [2:0]  bus_op = 0;
    logic [15:0] bus_addr = 0;
    logic        snoop_busy, tag_rd_en, tag_we, wb_req, snoop_done, snoop_hit, proto_err;
    logic [5:0]  tag_idx;
    logic [7:0]  tag_rd_tag;
    logic [1:0]  tag_rd_state, tag_wr_state;
    logic [63:0] blk_rd_data, wb_data;
    logic [15:0] wb_addr;

    logic [7:0]  m_tag [64];
    logic [1:0]  m_st  [64];
    logic [63:0] m_data[64];

    int total = 0, passed = 0;
    bit chk = 0;
    logic e_busy, e_rd, e_we, e_req, e_done, e_hit, e_err;
    logic [5:0]  e_idx;
    logic [1:0]  e_wst;
    logic [15:0] e_waddr, cap_waddr;
    logic [63:0] e_wdata, cap_wdata;

    snoop_responder #(.CORE_ID(0), .INDEX_W(6), .BLK_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
        .snoop_busy(snoop_busy), .tag_rd_en(tag_rd_en), .tag_idx(tag_idx), .tag_rd_tag(tag_rd_tag),
        .tag_rd_state(tag_rd_state), .blk_rd_data(blk_rd_data), .tag_we(tag_we), .tag_wr_state(tag_wr_state),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
        .snoop_done(snoop_done), .snoop_hit(snoop_hit), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // cache array the snooper talks to: one-cycle read latency, state writes on tag_we
    always @(posedge clk) begin
        if (tag_rd_en) begin
            tag_rd_tag   <= m_tag[tag_idx];
            tag_rd_state <= m_st[tag_idx];
            blk_rd_data  <= m_data[tag_idx];
        end
        if (tag_we) m_st[tag_idx] <= tag_wr_state;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) if (chk) begin
        check("busy", snoop_busy, e_busy);
        check("rd_en", tag_rd_en, e_rd);
        check("idx", tag_idx, e_idx);
        check("we", tag_we, e_we);
        check("wb_req", wb_req, e_req);
        check("done", snoop_done, e_done);
        check("hit", snoop_hit, e_hit);
        check("perr", proto_err, e_err);
        if (e_we) check("wr_state", tag_wr_state, e_wst);
        if (e_req) begin
            check("wb_addr", wb_addr, e_waddr);
            check("wb_data", wb_data, e_wdata);
            cap_waddr = wb_addr;
            cap_wdata = wb_data;
        end
    end

    task automatic cyc(input logic busy, rd, we, req, done, hit, err);
        {e_busy, e_rd, e_we, e_req, e_done, e_hit, e_err} = {busy, rd, we, req, done, hit, err};
        chk = 1;
        @(posedge clk);
        #1;
    endtask

    // transaction-level MSI model: owner/kind from the op code, outcome from the line's tag and state
    task automatic run_op(input logic [2:0] op, input logic [15:0] addr, input int ackd, input int hold);
        int k = (int'(op) - 1) / 2;
        bit own = op != NOOP && ((int'(op) - 1) % 2) == 0;
        logic [5:0] idx = addr[7:2];
        logic [1:0] st = m_st[idx];
        bit h = !own && op != NOOP && m_tag[idx] == addr[15:8] && st != I;
        logic [1:0] ns = !h ? st : (k == 0 ? (st == M ? S : st) : I);
        bit wb = h && st == M && k != 2;
        bit err = h && st == M && k == 2;
        bus_valid = 1; bus_op = op; bus_addr = addr;
        e_idx = idx; e_wst = ns; e_waddr = {addr[15:2], 2'b00}; e_wdata = m_data[idx];
        if (op == NOOP) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            bus_valid = 0;
            cyc(0, 0, 0, 0, 0, 0, 0);
            return;
        end
        cyc(0, !own, 0, 0, 0, 0, 0);
        if (!own) cyc(1, 0, 0, 0, 0, 0, 0);
        if (wb) begin
            for (int i = 1; i <= ackd; i++) begin
                wb_ack = (i == ackd);
                cyc(1, 0, 0, 1, 0, 0, 0);
            end
            wb_ack = 0;
        end
        cyc(1, 0, h && ns != st, 0, 1, h, err);
        for (int i = 0; i < hold; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        bus_valid = 0; bus_op = NOOP;
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("final_state", m_st[idx], ns);
    endtask

    task automatic set_line(input logic [5:0] idx, input logic [7:0] tg, input logic [1:0] st, input logic [63:0] d);
        m_tag[idx] = tg; m_st[idx] = st; m_data[idx] = d;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) set_line(6'(i), 8'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), {$urandom, $urandom});
        tag_rd_tag = 0; tag_rd_state = 0; blk_rd_data = 0;
        #12;
        check("rst_busy", snoop_busy, 0);
        check("rst_wb_req", wb_req, 0);
        check("rst_done", snoop_done, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        @(posedge clk); #1 rst_n = 1;
        cyc(0, 0, 0, 0, 0, 0, 0);

        // MODIFIED hit on READ_MISS_1: flush then SHARED
        set_line(9, 8'h01, M, 64'h1111_2222_3333_4444);
        run_op(RM1, 16'h0124, 3, 0);
        check("lit_wb_addr", cap_waddr, 16'h0124);
        check("lit_wb_data", cap_wdata, 64'h1111_2222_3333_4444);
        check("lit_shared", m_st[9], S);
        run_op(WM1, 16'h0124, 1, 0);
        check("lit_inv", m_st[9], I);
        set_line(9, 8'h01, M, 64'hDEAD_BEEF_0000_0001);
        run_op(RM0, 16'h0124, 1, 0);
        check("lit_own_keep", m_st[9], M);
        run_op(WM1, 16'h0226, 1, 0);
        check("lit_tag_miss", m_st[9], M);
        run_op(INV1, 16'h0125, 1, 0);
        check("lit_inval_mod", m_st[9], I);
        run_op(WM1, 16'h0124, 1, 5);
        set_line(9, 8'h01, M, 64'h0123_4567_89AB_CDEF);
        run_op(WM1, 16'h0127, 1, 2);
        check("lit_wm_flush", cap_waddr, 16'h0124);
        run_op(NOOP, 16'h0124, 1, 0);

        // reset asserted mid-writeback: wb_req drops immediately, line untouched
        set_line(9, 8'h01, M, 64'hCAFE);
        bus_valid = 1; bus_op = RM1; bus_addr = 16'h0124;
        e_idx = 9; e_waddr = 16'h0124; e_wdata = 64'hCAFE;
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        chk = 0;
        rst_n = 0;
        #1;
        check("abort_wb_req", wb_req, 0);
        check("abort_busy", snoop_busy, 0);
        bus_valid = 0; bus_op = NOOP;
        @(posedge clk); #1 rst_n = 1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("abort_no_write", m_st[9], M);

        for (int n = 0; n < 300; n++) begin
            logic [15:0] a = {7'd0, 1'($urandom_range(0, 1)), 8'($urandom)};
            run_op(3'($urandom_range(0, 6)), a, $urandom_range(1, 4), $urandom_range(0, 3));
            if (n % 7 == 0) begin
                logic [5:0] j = 6'($urandom);
                m_st[j] = 2'($urandom_range(0, 2));
            end
        end
        chk = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
